mem_responder: RTL and testbench

- Memory-side responder for the multicycle processor's MemRead/MemWrite strobes.
- Serves reads and writes from an internal DATA_W x 2^ADDR_W word array.
- Inserts a configurable number of wait states and signals completion with a one-cycle mem_ready pulse.
- Sits between the processor datapath (address/MDR path) and memory, replacing a zero-latency memory model.

---
 rtl/mem_pkg.sv | 16 +
 rtl/mem_array.sv | 22 ++
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding, default widths, MMIO address.
package mem_pkg;

  localparam int MEM_ADDR_W = 8;
  localparam int MEM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Top of the default address space; the top module recomputes this for its own ADDR_W.
  localparam logic [MEM_ADDR_W-1:0] MMIO_ADDR = '1;

endpackage

// File: rtl/mem_array.sv
// Word array with synchronous write and asynchronous read; no reset, so it maps onto RAM.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_responder.sv
// Multicycle memory responder: WAIT_CYCLES wait states, then a one-cycle mem_ready in RESP; requester holds strobes until then.
// Optional MEM_MMIO_EN maps the all-ones address to mmio_out (write) / mmio_in (read).
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
`ifdef MEM_MMIO_EN
  input  logic [DATA_W-1:0] mmio_in,
  output logic [DATA_W-1:0] mmio_out,
`endif
  output logic              req_err
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              is_mmio;
  logic              arr_we;
  logic              resp_rd;
  logic [DATA_W-1:0] arr_rd;
  logic [DATA_W-1:0] rd_val;

`ifdef MEM_MMIO_EN
  localparam logic [ADDR_W-1:0] MmioAddr = '1;
  logic [DATA_W-1:0] mmio_out_q;

  assign is_mmio  = (addr_q == MmioAddr);
  assign rd_val   = is_mmio ? mmio_in : arr_rd;
  assign mmio_out = mmio_out_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mmio_out_q <= '0;
    end else if (state_q == RESP && op_wr_q && is_mmio) begin
      mmio_out_q <= wdata_q;
    end
  end
`else
  assign is_mmio = 1'b0;
  assign rd_val  = arr_rd;
`endif

  // Writes commit on the edge that ends RESP, so an access aborted by reset never lands.
  assign arr_we  = (state_q == RESP) && op_wr_q && !is_mmio;
  assign resp_rd = (state_q == RESP) && !op_wr_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clock (clock),
    .we    (arr_we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (arr_rd)
  );

  // Read data is live during RESP and held from rdata_q afterwards.
  assign rdata     = resp_rd ? rd_val : rdata_q;
  assign mem_ready = ready_q;
  assign busy      = busy_q;
  assign req_err   = err_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_read || mem_write) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            op_wr_q <= mem_write;
            err_q   <= mem_read && mem_write;
            cnt_q   <= WaitInit;
            busy_q  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            ready_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (resp_rd) rdata_q <= rd_val;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
module tb_mem_responder;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rd  [2];
  logic       wr  [2];
  logic [7:0] ad  [2];
  logic [7:0] wd  [2];
  logic [7:0] rdt [2];
  logic       rdy [2];
  logic       bsy [2];
  logic       err [2];
`ifdef MEM_MMIO_EN
  logic [7:0] mmi [2];
  logic [7:0] mmo [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u0 (
    .clock(clock), .resetn(resetn), .mem_read(rd[0]), .mem_write(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rdt[0]), .mem_ready(rdy[0]), .busy(bsy[0]),
`ifdef MEM_MMIO_EN
    .mmio_in(mmi[0]), .mmio_out(mmo[0]),
`endif
    .req_err(err[0])
  );

  mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u1 (
    .clock(clock), .resetn(resetn), .mem_read(rd[1]), .mem_write(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rdt[1]), .mem_ready(rdy[1]), .busy(bsy[1]),
`ifdef MEM_MMIO_EN
    .mmio_in(mmi[1]), .mmio_out(mmo[1]),
`endif
    .req_err(err[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access on instance s; counts cycles (from the sampling edge) until mem_ready.
  task automatic run(input int s, input logic r, input logic w, input logic [7:0] a,
                     input logic [7:0] d, input logic chg, input logic [7:0] ca,
                     input logic [7:0] cd, output int lat, output int bcnt,
                     output int ecnt, output logic [7:0] rv);
    @(posedge clock); #1;
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    lat = -1; bcnt = 0; ecnt = 0; rv = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clock); @(negedge clock);
      if (bsy[s]) bcnt++;
      if (err[s]) ecnt++;
      if (c == 1 && chg) begin ad[s] = ca; wd[s] = cd; end
      if (rdy[s]) begin lat = c; rv = rdt[s]; break; end
    end
    rd[s] = 1'b0; wr[s] = 1'b0;
  endtask

  initial begin
    int lat, bc, ec, nr;
    logic [7:0] rv;
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; ad[i] = 0; wd[i] = 0;
`ifdef MEM_MMIO_EN
      mmi[i] = 8'h5A;
`endif
    end
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", rdy[0], 0);
    chk("rst_busy", bsy[0], 0);
    chk("rst_rdata", rdt[0], 0);
    chk("rst_err", err[0], 0);
    resetn = 1'b1;

    // Write then read with two wait states.
    run(0, 0, 1, 8'h10, 8'hA5, 0, 0, 0, lat, bc, ec, rv);
    chk("w2_latency", lat, 3);
    chk("w2_busy_cycles", bc, 3);
    @(negedge clock);
    chk("w2_idle_busy", bsy[0], 0);
    chk("w2_idle_ready", rdy[0], 0);
    run(0, 1, 0, 8'h10, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("r2_latency", lat, 3);
    chk("r2_rdata", rv, 8'hA5);
    chk("r2_no_err", ec, 0);

    // Zero wait states; held mem_read forces an IDLE gap then a second access.
    run(1, 0, 1, 8'h00, 8'h3C, 0, 0, 0, lat, bc, ec, rv);
    chk("w0_latency", lat, 1);
    @(posedge clock); #1;
    rd[1] = 1'b1; ad[1] = 8'h00;
    @(posedge clock); @(negedge clock);
    chk("r0_ready", rdy[1], 1);
    chk("r0_rdata", rdt[1], 8'h3C);
    @(posedge clock); @(negedge clock);
    chk("r0_gap_ready", rdy[1], 0);
    chk("r0_gap_busy", bsy[1], 0);
    @(posedge clock); @(negedge clock);
    chk("r0_second_ready", rdy[1], 1);
    rd[1] = 1'b0;
    @(posedge clock); @(negedge clock);
    chk("r0_after_ready", rdy[1], 0);

    // Both strobes: one req_err pulse, write wins.
    run(0, 1, 1, 8'h20, 8'h55, 0, 0, 0, lat, bc, ec, rv);
    chk("both_err_pulses", ec, 1);
    chk("both_latency", lat, 3);
    @(negedge clock);
    chk("both_err_gone", err[0], 0);
    chk("both_rdata_held", rdt[0], 8'hA5);
    run(0, 1, 0, 8'h20, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("both_readback", rv, 8'h55);
    repeat (2) @(negedge clock);
    chk("rdata_hold_idle", rdt[0], 8'h55);

    // Reset during WAIT aborts a pending write.
    run(0, 0, 1, 8'h30, 8'h77, 0, 0, 0, lat, bc, ec, rv);
    @(posedge clock); #1;
    wr[0] = 1'b1; ad[0] = 8'h30; wd[0] = 8'h99;
    @(posedge clock); @(negedge clock);
    chk("abort_busy_wait", bsy[0], 1);
    resetn = 1'b0;
    #1;
    chk("abort_busy", bsy[0], 0);
    chk("abort_ready", rdy[0], 0);
    chk("abort_rdata", rdt[0], 0);
    chk("abort_rdata_u1", rdt[1], 0);
    @(posedge clock); @(posedge clock); #1;
    wr[0] = 1'b0;
    resetn = 1'b1;
    nr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (rdy[0]) nr++;
    end
    chk("abort_no_ready", nr, 0);
    run(0, 1, 0, 8'h30, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("abort_readback", rv, 8'h77);

    // Inputs changed mid-WAIT are ignored.
    run(0, 0, 1, 8'h41, 8'hE7, 0, 0, 0, lat, bc, ec, rv);
    run(0, 0, 1, 8'h40, 8'h11, 1, 8'h41, 8'h22, lat, bc, ec, rv);
    chk("midchg_latency", lat, 3);
    run(0, 1, 0, 8'h40, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("midchg_40", rv, 8'h11);
    run(0, 1, 0, 8'h41, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("midchg_41", rv, 8'hE7);

    // Top address: MMIO when enabled, plain RAM otherwise.
    run(0, 0, 1, 8'hFF, 8'hC3, 0, 0, 0, lat, bc, ec, rv);
    @(negedge clock);
    chk("top_wr_rdata_held", rdt[0], 8'hE7);
`ifdef MEM_MMIO_EN
    chk("mmio_out", mmo[0], 8'hC3);
    run(0, 1, 0, 8'hFF, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("mmio_in_read", rv, 8'h5A);
`else
    run(0, 1, 0, 8'hFF, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("top_ram_read", rv, 8'hC3);
`endif
    run(1, 1, 0, 8'h00, 8'h00, 0, 0, 0, lat, bc, ec, rv);
    chk("u1_isolated", rv, 8'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
